// File: rtl/led_frame_streamer.sv
// Frame snapshot and GRB word serialiser for the WS2812B driver.
// Each pixel's cell bits are mapped to a 24-bit word and handed to the driver on its load/shift handshake.
module led_frame_streamer #(
    parameter int          NUM_PIXELS = 64,
    parameter int          ROW_W      = 8,
    parameter int          PIX_W      = $clog2(NUM_PIXELS),
    parameter logic [7:0]  ON_LEVEL   = 8'h90,
    parameter logic [7:0]  OFF_LEVEL  = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_valid,
    input  logic [NUM_PIXELS-1:0] cells_g,
    input  logic [NUM_PIXELS-1:0] cells_r,
    input  logic [NUM_PIXELS-1:0] cells_b,
    input  logic [2:0]            ch_en,
    input  logic [2:0]            bright_shift,
    input  logic                  serpentine,
    input  logic                  load_sreg,
    input  logic                  shift,
    output logic                  serial_out,
    output logic                  frame_done,
    output logic                  busy,
    output logic [PIX_W-1:0]      pixel_idx
);

    // state  | meaning
    // IDLE   | no frame; loads give a dark word
    // STREAM | loading pixel words from the snapshot
    // DRAIN  | last word loaded; counting its 24 shifts
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    localparam logic [PIX_W:0]   ROW_EXT  = (PIX_W+1)'(ROW_W);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    state_t                 state_q, state_d;
    logic [23:0]            shift_reg_q, shift_reg_d;
    logic [PIX_W-1:0]       pixel_idx_q, pixel_idx_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic                   pending_q, pending_d;
    logic [NUM_PIXELS-1:0]  snap_g_q, snap_g_d, snap_r_q, snap_r_d, snap_b_q, snap_b_d;
    logic [NUM_PIXELS-1:0]  shd_g_q, shd_g_d, shd_r_q, shd_r_d, shd_b_q, shd_b_d;

    logic [PIX_W:0]         p_ext, row_ext, col_ext;
    logic [PIX_W-1:0]       src_idx;
    logic [7:0]             lvl, byte_g, byte_r, byte_b;

    // Odd rows run backwards on the physical strip when serpentine wiring is selected.
    always_comb begin
        p_ext   = {1'b0, pixel_idx_q};
        row_ext = p_ext / ROW_EXT;
        col_ext = p_ext % ROW_EXT;
        src_idx = pixel_idx_q;
        if (serpentine && row_ext[0]) begin
            src_idx = PIX_W'(row_ext * ROW_EXT + (ROW_EXT - (PIX_W+1)'(1) - col_ext));
        end
        lvl    = ON_LEVEL >> bright_shift;
        byte_g = ch_en[2] ? (snap_g_q[src_idx] ? lvl : OFF_LEVEL) : 8'h00;
        byte_r = ch_en[1] ? (snap_r_q[src_idx] ? lvl : OFF_LEVEL) : 8'h00;
        byte_b = ch_en[0] ? (snap_b_q[src_idx] ? lvl : OFF_LEVEL) : 8'h00;
    end

    always_comb begin
        state_d      = state_q;
        shift_reg_d  = shift_reg_q;
        pixel_idx_d  = pixel_idx_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;
        snap_g_d     = snap_g_q;
        snap_r_d     = snap_r_q;
        snap_b_d     = snap_b_q;
        shd_g_d      = shd_g_q;
        shd_r_d      = shd_r_q;
        shd_b_d      = shd_b_q;

        if (state_q != IDLE && frame_valid) begin
            pending_d = 1'b1;
            shd_g_d   = cells_g;
            shd_r_d   = cells_r;
            shd_b_d   = cells_b;
        end

        if (load_sreg) begin
            shift_reg_d = 24'h0;
            if (state_q == STREAM) begin
                shift_reg_d = {byte_g, byte_r, byte_b};
                if (pixel_idx_q == LAST_PIX) begin
                    pixel_idx_d = '0;
                    bit_cnt_d   = 5'd0;
                    state_d     = DRAIN;
                end else begin
                    pixel_idx_d = pixel_idx_q + PIX_W'(1);
                end
            end
        end else if (shift) begin
            shift_reg_d = {shift_reg_q[22:0], 1'b0};
            if (state_q == DRAIN) begin
                if (bit_cnt_q == 5'd23) begin
                    frame_done_d = 1'b1;
                    bit_cnt_d    = 5'd0;
                    // A frame arriving on this very cycle counts as pending and is the newest.
                    if (pending_q || frame_valid) begin
                        snap_g_d    = frame_valid ? cells_g : shd_g_q;
                        snap_r_d    = frame_valid ? cells_r : shd_r_q;
                        snap_b_d    = frame_valid ? cells_b : shd_b_q;
                        pending_d   = 1'b0;
                        pixel_idx_d = '0;
                        state_d     = STREAM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end

        if (state_q == IDLE && frame_valid) begin
            snap_g_d    = cells_g;
            snap_r_d    = cells_r;
            snap_b_d    = cells_b;
            pixel_idx_d = '0;
            state_d     = STREAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_reg_q  <= 24'h0;
            pixel_idx_q  <= '0;
            bit_cnt_q    <= 5'd0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            snap_g_q     <= '0;
            snap_r_q     <= '0;
            snap_b_q     <= '0;
            shd_g_q      <= '0;
            shd_r_q      <= '0;
            shd_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            pixel_idx_q  <= pixel_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            snap_g_q     <= snap_g_d;
            snap_r_q     <= snap_r_d;
            snap_b_q     <= snap_b_d;
            shd_g_q      <= shd_g_d;
            shd_r_q      <= shd_r_d;
            shd_b_q      <= shd_b_d;
        end
    end

    assign serial_out = shift_reg_q[23];
    assign frame_done = frame_done_q;
    assign busy       = (state_q == STREAM);
    assign pixel_idx  = pixel_idx_q;

endmodule

// File: tb/tb_led_frame_streamer.sv
// Directed and randomized bench for led_frame_streamer; words are reassembled from serial_out
// and compared with a pixel-level model of the frame.
module tb_led_frame_streamer;

    localparam int N  = 64;
    localparam int RW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_valid = 1'b0;
    logic [N-1:0] cells_g = '0, cells_r = '0, cells_b = '0;
    logic [2:0]   ch_en = 3'b000, bright_shift = 3'd0;
    logic         serpentine = 1'b0, load_sreg = 1'b0, shift = 1'b0;
    logic         serial_out, frame_done, busy;
    logic [5:0]   pixel_idx;

    int n_cmp = 0, n_err = 0, n_done = 0;
    logic [N-1:0] snap_g, snap_r, snap_b, shd_g, shd_r, shd_b;
    bit           pend_m = 0;

    led_frame_streamer dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
        .cells_g(cells_g), .cells_r(cells_r), .cells_b(cells_b),
        .ch_en(ch_en), .bright_shift(bright_shift), .serpentine(serpentine),
        .load_sreg(load_sreg), .shift(shift), .serial_out(serial_out),
        .frame_done(frame_done), .busy(busy), .pixel_idx(pixel_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) n_done++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_cells();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: physical pixel -> logical cell -> channel bytes, using plain integer math.
    function automatic logic [23:0] model_word(int p);
        int row, col, s, lvl;
        logic [7:0] g, r, b;
        row = p / RW;
        col = p % RW;
        s   = (serpentine && (row % 2 == 1)) ? row * RW + (RW - 1 - col) : p;
        lvl = 144 / (1 << bright_shift);
        g = (ch_en[2] && snap_g[s]) ? 8'(lvl) : 8'h00;
        r = (ch_en[1] && snap_r[s]) ? 8'(lvl) : 8'h00;
        b = (ch_en[0] && snap_b[s]) ? 8'(lvl) : 8'h00;
        return {g, r, b};
    endfunction

    task automatic read_word(bit both, output logic [23:0] w);
        load_sreg = 1'b1;
        shift     = both;
        tick();
        load_sreg = 1'b0;
        w = '0;
        for (int i = 0; i < 24; i++) begin
            w = {w[22:0], serial_out};
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
    endtask

    task automatic start_frame(logic [N-1:0] g, logic [N-1:0] r, logic [N-1:0] b);
        cells_g = g; cells_r = r; cells_b = b;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        snap_g = g; snap_r = r; snap_b = b;
        cells_g = rand_cells(); cells_r = rand_cells(); cells_b = rand_cells();
        check("start_busy", busy, 1);
        check("start_pixel_idx", pixel_idx, 0);
    endtask

    task automatic pulse_fv;
        cells_g = rand_cells(); cells_r = rand_cells(); cells_b = rand_cells();
        shd_g = cells_g; shd_r = cells_r; shd_b = cells_b;
        pend_m = 1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        cells_g = rand_cells(); cells_r = rand_cells(); cells_b = rand_cells();
    endtask

    task automatic do_pixel(int p, bit both);
        logic [23:0] w, exp;
        check("pixel_idx", pixel_idx, p);
        exp = model_word(p);
        read_word(both, w);
        check("word", w, exp);
        check("frame_done", frame_done, (p == N - 1) ? 1 : 0);
    endtask

    // both_mode: 0 = plain load, 1 = load with simultaneous shift, 2 = random
    task automatic run_frame(bit rnd, bit pend_test, int both_mode);
        int done0;
        bit b;
        done0 = n_done;
        for (int p = 0; p < N; p++) begin
            if (rnd) begin
                ch_en        = 3'($urandom_range(0, 7));
                bright_shift = 3'($urandom_range(0, 7));
                serpentine   = 1'($urandom_range(0, 1));
            end
            if (pend_test && (p == 5 || p == 20)) pulse_fv();
            b = (both_mode == 1) ? 1'b1 : (both_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_pixel(p, b);
        end
        check("busy_at_done", busy, pend_m ? 1 : 0);
        tick();
        check("done_one_cycle", frame_done, 0);
        check("done_count", n_done - done0, 1);
        if (pend_m) begin
            snap_g = shd_g; snap_r = shd_r; snap_b = shd_b;
            pend_m = 0;
            check("next_frame_idx", pixel_idx, 0);
        end
    endtask

    initial begin
        logic [23:0] w;
        int done0;

        tick(); tick();
        check("rst_serial_out", serial_out, 0);
        check("rst_pixel_idx", pixel_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        tick();

        cells_g = rand_cells();
        ch_en = 3'b111;
        read_word(1'b0, w);
        check("idle_dark_word", w, 24'h0);
        check("idle_pixel_idx", pixel_idx, 0);

        // Reset in the middle of a frame with a live word sitting in the shift register.
        bright_shift = 3'd0; serpentine = 1'b0;
        start_frame('1, '1, '1);
        for (int p = 0; p < 10; p++) do_pixel(p, 1'b0);
        load_sreg = 1'b1;
        tick();
        load_sreg = 1'b0;
        w = model_word(10);
        check("pre_reset_msb", serial_out, w[23]);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_serial_out", serial_out, 0);
        check("mid_rst_pixel_idx", pixel_idx, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        done0 = n_done;
        shift = 1'b1;
        repeat (30) tick();
        shift = 1'b0;
        check("post_rst_no_done", n_done - done0, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_frame_done", frame_done, 0);

        ch_en = 3'b100; bright_shift = 3'd0; serpentine = 1'b0;
        start_frame('1, '0, '0);
        run_frame(1'b0, 1'b0, 0);

        ch_en = 3'b111; bright_shift = 3'd3;
        start_frame('0, 64'h1, '0);
        run_frame(1'b0, 1'b0, 0);

        ch_en = 3'b111; bright_shift = 3'd0; serpentine = 1'b1;
        start_frame('0, '0, 64'h100);
        run_frame(1'b0, 1'b0, 0);
        serpentine = 1'b0;
        start_frame('0, '0, 64'h100);
        run_frame(1'b0, 1'b0, 0);

        // Load and shift together: load must win.
        ch_en = 3'b111; bright_shift = 3'd0;
        start_frame(rand_cells(), rand_cells(), rand_cells());
        run_frame(1'b0, 1'b0, 1);

        repeat (2) begin
            start_frame(rand_cells(), rand_cells(), rand_cells());
            run_frame(1'b1, 1'b0, 2);
        end

        // Two frame_valid pulses mid-stream: the second one streams next, back to back.
        start_frame(rand_cells(), rand_cells(), rand_cells());
        run_frame(1'b1, 1'b1, 2);
        run_frame(1'b1, 1'b0, 2);
        check("pending_cleared_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
